// File: rtl/prog_delay_pkg.sv
// Shared helpers for the programmable delay line: select-width derivation
// and the delay_sel clamp used at every enabled edge.
package prog_delay_pkg;

   typedef struct packed {
      logic [31:0] deff;
      logic        err;
   } clamp_t;

   function automatic int sel_width(input int max_delay);
      return $clog2(max_delay + 1);
   endfunction

   // Out-of-range selects are clamped to the nearest legal delay and flagged.
   function automatic clamp_t clamp_delay(input logic [31:0] sel, input logic [31:0] max_d);
      clamp_t r;
      r.err = (sel == 32'd0) || (sel > max_d);
      if (sel == 32'd0)
         r.deff = 32'd1;
      else if (sel > max_d)
         r.deff = max_d;
      else
         r.deff = sel;
      return r;
   endfunction

endpackage

// File: rtl/delay_tap_shreg.sv
// Clearable, enable-gated shift register with a combinational tap select.
module delay_tap_shreg #(
   parameter int WIDTH     = 1,
   parameter int MAX_DELAY = 16,
   parameter int SEL_W     = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_din,
   input  logic [SEL_W-1:0] i_tap_idx,
   output logic [WIDTH-1:0] o_tap
);

   logic [MAX_DELAY-1:0][WIDTH-1:0] r_stage;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr)
         r_stage <= '0;
      else if (i_en)
         r_stage <= {r_stage[MAX_DELAY-2:0], i_din};
   end

   // Compare-based mux keeps the select width independent of the array depth.
   always_comb begin
      o_tap = '0;
      for (int i = 0; i < MAX_DELAY; i++)
         if (i_tap_idx == SEL_W'(i))
            o_tap = r_stage[i];
   end

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line: clamp, fill tracking, output inversion
// and registered dout/dout_valid/sel_err around a tapped shift register.
module prog_delay_line
   import prog_delay_pkg::*;
#(
   parameter int WIDTH     = 1,
   parameter int MAX_DELAY = 16,
   parameter int SEL_W     = sel_width(MAX_DELAY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   input  logic [SEL_W-1:0] delay_sel,
   input  logic [WIDTH-1:0] inv_mask,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             sel_err
);

   clamp_t           w_clamp;
   logic [SEL_W-1:0] w_deff;
   logic [SEL_W-1:0] w_tap_idx;
   logic [WIDTH-1:0] w_tap;
   logic             w_unused_hi;

   logic [SEL_W-1:0] r_fill;
   logic [WIDTH-1:0] r_dout;
   logic             r_valid;
   logic             r_err;

   assign w_clamp     = clamp_delay(32'(delay_sel), 32'(MAX_DELAY));
   assign w_deff      = w_clamp.deff[SEL_W-1:0];
   assign w_unused_hi = ^w_clamp.deff[31:SEL_W];
   assign w_tap_idx   = w_deff - SEL_W'(1);

   delay_tap_shreg #(
      .WIDTH     (WIDTH),
      .MAX_DELAY (MAX_DELAY),
      .SEL_W     (SEL_W)
   ) u_shreg (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_clr     (clr),
      .i_en      (en),
      .i_din     (din),
      .i_tap_idx (w_tap_idx),
      .o_tap     (w_tap)
   );

   // Valid is judged on the pre-edge fill so a sample must truly cross Deff stages.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_fill  <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else if (en) begin
         r_dout  <= w_tap ^ inv_mask;
         r_valid <= (r_fill >= w_deff);
         r_err   <= w_clamp.err;
         if (r_fill != SEL_W'(MAX_DELAY))
            r_fill <= r_fill + SEL_W'(1);
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_valid;
   assign sel_err    = r_err;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line: vector table plus hand sequences for
// delay changes and clr-mid-stream refill.
module tb_prog_delay_line;

   localparam int WIDTH     = 8;
   localparam int MAX_DELAY = 16;
   localparam int SEL_W     = 5;

   logic             clk = 1'b0;
   logic             rst, en, clr;
   logic [WIDTH-1:0] din, inv_mask, dout;
   logic [SEL_W-1:0] delay_sel;
   logic             dout_valid, sel_err;

   int errors = 0;
   int checks = 0;

   prog_delay_line #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clr        (clr),
      .din        (din),
      .delay_sel  (delay_sel),
      .inv_mask   (inv_mask),
      .dout       (dout),
      .dout_valid (dout_valid),
      .sel_err    (sel_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst, clr, en;
      logic [7:0] din;
      logic [4:0] sel;
      logic [7:0] inv;
      logic [7:0] e_dout;
      logic       e_v, e_e;
   } vec_t;

   vec_t tbl[$];

   task automatic step(input logic r, input logic c, input logic e,
                       input logic [7:0] d, input logic [4:0] s, input logic [7:0] m);
      rst = r; clr = c; en = e; din = d; delay_sel = s; inv_mask = m;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] ed, input logic ev, input logic ee);
      checks++;
      if (dout !== ed || dout_valid !== ev || sel_err !== ee) begin
         errors++;
         $display("FAIL %s: got dout=%h valid=%b err=%b, want dout=%h valid=%b err=%b",
                  name, dout, dout_valid, sel_err, ed, ev, ee);
      end
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; en = 1'b0; din = '0; delay_sel = 5'd1; inv_mask = '0;

      // Reset, then fill with D=5
      tbl.push_back('{"rst0", 1,0,0, 8'h00, 5'd5, 8'h00, 8'h00, 0, 0});
      tbl.push_back('{"rst1", 1,0,0, 8'h00, 5'd5, 8'h00, 8'h00, 0, 0});
      for (int n = 1; n <= 8; n++)
         tbl.push_back('{$sformatf("fill%0d", n), 0,0,1, 8'(n), 5'd5, 8'h00,
                         (n > 5) ? 8'(n - 5) : 8'h00, (n > 5), 0});
      // Enable gating, D=3 (clr with en=1 discards FF)
      tbl.push_back('{"g_clr", 0,1,1, 8'hFF, 5'd3, 8'h00, 8'h00, 0, 0});
      tbl.push_back('{"g_A",   0,0,1, 8'hA1, 5'd3, 8'h00, 8'h00, 0, 0});
      tbl.push_back('{"g_x1",  0,0,0, 8'h55, 5'd3, 8'h00, 8'h00, 0, 0});
      tbl.push_back('{"g_x2",  0,0,0, 8'h66, 5'd3, 8'h00, 8'h00, 0, 0});
      tbl.push_back('{"g_B",   0,0,1, 8'hB2, 5'd3, 8'h00, 8'h00, 0, 0});
      tbl.push_back('{"g_C",   0,0,1, 8'hC3, 5'd3, 8'h00, 8'h00, 0, 0});
      tbl.push_back('{"g_D",   0,0,1, 8'hD4, 5'd3, 8'h00, 8'hA1, 1, 0});
      tbl.push_back('{"g_hold",0,0,0, 8'h00, 5'd3, 8'h00, 8'hA1, 1, 0});
      tbl.push_back('{"g_E",   0,0,1, 8'hE5, 5'd3, 8'h00, 8'hB2, 1, 0});
      // Inversion, D=1; clr acts even with en=0
      tbl.push_back('{"i_clr", 0,1,0, 8'h00, 5'd1, 8'h00, 8'h00, 0, 0});
      tbl.push_back('{"i_e1",  0,0,1, 8'h3C, 5'd1, 8'hF0, 8'hF0, 0, 0});
      tbl.push_back('{"i_e2",  0,0,1, 8'h5A, 5'd1, 8'hF0, 8'hCC, 1, 0});
      tbl.push_back('{"i_h1",  0,0,0, 8'h11, 5'd1, 8'h0F, 8'hCC, 1, 0});
      tbl.push_back('{"i_h2",  0,0,0, 8'h11, 5'd1, 8'hFF, 8'hCC, 1, 0});
      tbl.push_back('{"i_e3",  0,0,1, 8'h22, 5'd1, 8'h00, 8'h5A, 1, 0});
      // rst beats en and clr; clamp/error boundaries
      tbl.push_back('{"c_rst", 1,1,1, 8'hAA, 5'd0,  8'h00, 8'h00, 0, 0});
      tbl.push_back('{"c_s0a", 0,0,1, 8'h11, 5'd0,  8'h00, 8'h00, 0, 1});
      tbl.push_back('{"c_s0b", 0,0,1, 8'h22, 5'd0,  8'h00, 8'h11, 1, 1});
      tbl.push_back('{"c_hold",0,0,0, 8'h99, 5'd4,  8'h00, 8'h11, 1, 1});
      tbl.push_back('{"c_s4a", 0,0,1, 8'h33, 5'd4,  8'h00, 8'h00, 0, 0});
      tbl.push_back('{"c_s31", 0,0,1, 8'h44, 5'd31, 8'h00, 8'h00, 0, 1});
      tbl.push_back('{"c_s4b", 0,0,1, 8'h55, 5'd4,  8'h00, 8'h11, 1, 0});
      tbl.push_back('{"c_s16", 0,0,1, 8'h66, 5'd16, 8'h00, 8'h00, 0, 0});
      tbl.push_back('{"c_s17", 0,0,1, 8'h77, 5'd17, 8'h00, 8'h00, 0, 1});

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].clr, tbl[i].en, tbl[i].din, tbl[i].sel, tbl[i].inv);
         check(tbl[i].name, tbl[i].e_dout, tbl[i].e_v, tbl[i].e_e);
      end

      // Delay change with saturated fill: dout after edge m is din of edge m-D = m-D
      step(0, 1, 0, 8'h00, 5'd4, 8'h00);
      check("dc_clr", 8'h00, 0, 0);
      for (int m = 1; m <= 20; m++) begin
         step(0, 0, 1, 8'(m), 5'd4, 8'h00);
         check($sformatf("dc4_%0d", m), (m > 4) ? 8'(m - 4) : 8'h00, (m > 4), 0);
      end
      for (int m = 21; m <= 22; m++) begin
         step(0, 0, 1, 8'(m), 5'd2, 8'h00);
         check($sformatf("dc2_%0d", m), 8'(m - 2), 1, 0);
      end
      for (int m = 23; m <= 25; m++) begin
         step(0, 0, 1, 8'(m), 5'd12, 8'h00);
         check($sformatf("dc12_%0d", m), 8'(m - 12), 1, 0);
      end

      // Increase shortly after clr: D=2 for 3 edges, then D=6
      step(0, 1, 1, 8'hEE, 5'd2, 8'h00);
      check("inc_clr", 8'h00, 0, 0);
      for (int m = 1; m <= 9; m++) begin
         int d;
         d = (m <= 3) ? 2 : 6;
         step(0, 0, 1, 8'(100 + m), 5'(d), 8'h00);
         check($sformatf("inc_%0d", m), (m > d) ? 8'(100 + m - d) : 8'h00, (m > d), 0);
      end

      // clr with en mid-stream: din discarded, refill latency restarts at D=6
      step(0, 1, 1, 8'hEE, 5'd6, 8'h00);
      check("cp_clr", 8'h00, 0, 0);
      for (int m = 1; m <= 8; m++) begin
         step(0, 0, 1, 8'(8'h40 + m), 5'd6, 8'h00);
         check($sformatf("cp_%0d", m), (m > 6) ? 8'(8'h40 + m - 6) : 8'h00, (m > 6), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
